// File: rtl/mem_traffic_gen_if.sv
// Memory bus between the traffic generator and a memory responder.
//   mem_valid  : request, held until mem_ready completes the transaction
//   mem_instr  : instruction-fetch flag (the generator only issues data accesses)
//   mem_ready  : responder completion
//   mem_addr   : word-aligned byte address
//   mem_wdata  : write data
//   mem_wstrb  : byte enables, 4'hF = write, 4'h0 = read
//   mem_rdata  : read data, valid when mem_valid and mem_ready are both high
// master = request side (generator), slave = responder side.
interface mem_traffic_gen_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_traffic_gen.sv
// Memory traffic generator: on start, writes NUM_WORDS words of an address-derived
// pattern beginning at BASE_ADDR, then reads them back and counts mismatches.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse launching a run (honoured only when idle or finished)
//   bus             : memory request interface (master side)
//   busy            : run in progress
//   done            : sticky end-of-run flag, high while finished
//   err_count       : saturating count of readback mismatches
//   first_err_addr  : address of the first mismatching word
//   timeout         : sticky flag, a transaction got no mem_ready within TIMEOUT cycles
module mem_traffic_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned NUM_WORDS = 16,
    parameter logic [31:0] SEED      = 32'hA5A5_5A5A,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    mem_traffic_gen_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [31:0]       first_err_addr,
    output logic              timeout
);

    localparam logic [15:0] LastIdx  = 16'(NUM_WORDS - 1);
    localparam logic [31:0] WaitLast = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrGap,
        StRdReq,
        StRdGap,
        StFin
    } state_e;

    state_e      state_q;
    logic        valid_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [15:0] idx_q;
    logic [31:0] wait_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] err_q;
    logic [31:0] first_err_q;
    logic        timeout_q;

    logic last_word;
    logic rd_mismatch;

    assign last_word   = (idx_q == LastIdx);
    assign rd_mismatch = (bus.mem_rdata != (addr_q ^ SEED));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StFin: begin
                    if (start) begin
                        state_q     <= StWrReq;
                        valid_q     <= 1'b1;
                        addr_q      <= BASE_ADDR;
                        wdata_q     <= BASE_ADDR ^ SEED;
                        wstrb_q     <= 4'hF;
                        idx_q       <= '0;
                        wait_q      <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= '0;
                        first_err_q <= '0;
                        timeout_q   <= 1'b0;
                    end
                end

                StWrReq: begin
                    if (bus.mem_ready) begin
                        valid_q <= 1'b0;
                        if (last_word) begin
                            // Switch to the read phase; read requests carry no data.
                            state_q <= StRdGap;
                            idx_q   <= '0;
                            addr_q  <= BASE_ADDR;
                            wdata_q <= '0;
                            wstrb_q <= 4'h0;
                        end else begin
                            state_q <= StWrGap;
                            idx_q   <= idx_q + 16'd1;
                            addr_q  <= addr_q + 32'd4;
                            wdata_q <= (addr_q + 32'd4) ^ SEED;
                        end
                    end else if (wait_q == WaitLast) begin
                        state_q   <= StFin;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end

                StWrGap: begin
                    state_q <= StWrReq;
                    valid_q <= 1'b1;
                    wait_q  <= '0;
                end

                StRdGap: begin
                    state_q <= StRdReq;
                    valid_q <= 1'b1;
                    wait_q  <= '0;
                end

                StRdReq: begin
                    if (bus.mem_ready) begin
                        valid_q <= 1'b0;
                        if (rd_mismatch) begin
                            if (err_q != 16'hFFFF) begin
                                err_q <= err_q + 16'd1;
                            end
                            if (err_q == 16'h0000) begin
                                first_err_q <= addr_q;
                            end
                        end
                        if (last_word) begin
                            state_q <= StFin;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRdGap;
                            idx_q   <= idx_q + 16'd1;
                            addr_q  <= addr_q + 32'd4;
                        end
                    end else if (wait_q == WaitLast) begin
                        state_q   <= StFin;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_valid = valid_q;
    assign bus.mem_instr = 1'b0;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_count      = err_q;
    assign first_err_addr = first_err_q;
    assign timeout        = timeout_q;

endmodule

// File: tb/tb_mem_traffic_gen.sv
module tb_mem_traffic_gen;
    localparam logic [31:0] Base = 32'h0000_1000;
    localparam logic [31:0] Seed = 32'hA5A5_5A5A;
    localparam int          Nw   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // dut0: default parameters
    logic        start0 = 1'b0;
    logic        ready0 = 1'b0;
    logic [31:0] rdata0 = '0;
    logic        busy0, done0, timeout0;
    logic [15:0] err0;
    logic [31:0] first0;
    mem_traffic_gen_if b0 ();
    assign b0.mem_ready = ready0;
    assign b0.mem_rdata = rdata0;
    mem_traffic_gen dut0 (
        .clk(clk), .rst(rst), .start(start0), .bus(b0), .busy(busy0), .done(done0),
        .err_count(err0), .first_err_addr(first0), .timeout(timeout0)
    );

    // dut1: short timeout
    logic        start1 = 1'b0;
    logic        ready1 = 1'b0;
    logic [31:0] rdata1 = '0;
    logic        busy1, done1, timeout1;
    logic [15:0] err1;
    logic [31:0] first1;
    mem_traffic_gen_if b1 ();
    assign b1.mem_ready = ready1;
    assign b1.mem_rdata = rdata1;
    mem_traffic_gen #(.TIMEOUT(8)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bus(b1), .busy(busy1), .done(done1),
        .err_count(err1), .first_err_addr(first1), .timeout(timeout1)
    );

    // dut2: single word at the top of the address space
    logic        start2 = 1'b0;
    logic        ready2 = 1'b0;
    logic [31:0] rdata2 = '0;
    logic        busy2, done2, timeout2;
    logic [15:0] err2;
    logic [31:0] first2;
    mem_traffic_gen_if b2 ();
    assign b2.mem_ready = ready2;
    assign b2.mem_rdata = rdata2;
    mem_traffic_gen #(.NUM_WORDS(1), .BASE_ADDR(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bus(b2), .busy(busy2), .done(done2),
        .err_count(err2), .first_err_addr(first2), .timeout(timeout2)
    );

    // ---------------- dut0 responder with transaction-level model ----------------
    int          r_wait_fixed = 0;   // < 0 selects random wait states
    int unsigned r_wait_max   = 0;
    logic [15:0] r_corrupt    = '0;
    bit          r_noise      = 1'b0;
    int          r_txn        = 0;
    bit          r_in_txn     = 1'b0;
    bit          r_seen       = 1'b0;
    int          r_gap        = 0;
    int          r_wait_left  = 0;
    logic [31:0] r_addr = '0, r_wdata = '0;
    logic [3:0]  r_wstrb = '0;

    always @(negedge clk) begin
        logic [31:0] ea, ed;
        logic [3:0]  es;
        int          ridx;
        if (rst) begin
            r_in_txn = 1'b0;
            ready0   = 1'b0;
        end else if (b0.mem_valid) begin
            if (!r_in_txn) begin
                r_in_txn = 1'b1;
                r_addr   = b0.mem_addr;
                r_wdata  = b0.mem_wdata;
                r_wstrb  = b0.mem_wstrb;
                if (r_txn < Nw) begin
                    ea = Base + 32'(4 * r_txn);
                    ed = ea ^ Seed;
                    es = 4'hF;
                end else begin
                    ea = Base + 32'(4 * (r_txn - Nw));
                    ed = '0;
                    es = 4'h0;
                end
                checks++;
                if (b0.mem_addr !== ea || b0.mem_wdata !== ed || b0.mem_wstrb !== es ||
                    b0.mem_instr !== 1'b0) begin
                    failures++;
                    $display("FAIL txn%0d got addr=%h wdata=%h wstrb=%h instr=%b exp %h %h %h 0",
                             r_txn, b0.mem_addr, b0.mem_wdata, b0.mem_wstrb, b0.mem_instr,
                             ea, ed, es);
                end
                if (r_seen) begin
                    checks++;
                    if (r_gap != 1) begin
                        failures++;
                        $display("FAIL gap_before_txn%0d got %0d exp 1", r_txn, r_gap);
                    end
                end
                r_wait_left = (r_wait_fixed >= 0) ? r_wait_fixed
                                                  : int'($urandom_range(r_wait_max, 0));
            end else begin
                checks++;
                if ({b0.mem_addr, b0.mem_wdata, b0.mem_wstrb} !== {r_addr, r_wdata, r_wstrb}) begin
                    failures++;
                    $display("FAIL hold_stable txn%0d got %h/%h/%h exp %h/%h/%h", r_txn,
                             b0.mem_addr, b0.mem_wdata, b0.mem_wstrb, r_addr, r_wdata, r_wstrb);
                end
            end
            r_gap = 0;
            if (r_wait_left == 0) begin
                ready0 = 1'b1;
                ridx   = r_txn - Nw;
                if (ridx >= 0 && ridx < Nw) begin
                    rdata0 = (Base + 32'(4 * ridx)) ^ Seed;
                    if (r_corrupt[ridx]) rdata0 = rdata0 ^ 32'h0000_0100;
                end else begin
                    rdata0 = $urandom;
                end
            end else begin
                ready0 = 1'b0;
                rdata0 = $urandom;
                r_wait_left--;
            end
        end else begin
            ready0 = r_noise ? 1'($urandom_range(1, 0)) : 1'b0;
            rdata0 = $urandom;
            r_gap++;
        end
    end

    always @(posedge clk) begin
        if (!rst && b0.mem_valid && b0.mem_ready) begin
            r_txn++;
            r_in_txn = 1'b0;
            r_seen   = 1'b1;
        end
    end

    // ---------------- dut1 responder: never completes the third transaction -------
    int t1_hs = 0, t1_reads = 0;
    always @(posedge clk) begin
        if (rst) begin
            t1_hs    = 0;
            t1_reads = 0;
        end else if (b1.mem_valid && b1.mem_ready) begin
            t1_hs++;
            if (b1.mem_wstrb == 4'h0) t1_reads++;
        end
    end
    always @(negedge clk) begin
        ready1 = b1.mem_valid && (t1_hs != 2);
        rdata1 = b1.mem_addr ^ Seed;
    end

    // ---------------- dut2 responder: zero wait, returns the expected pattern -----
    always @(negedge clk) begin
        ready2 = b2.mem_valid;
        rdata2 = 32'h5A5A_A5A6;
    end

    // ---------------- scenarios ----------------
    task automatic run0(input int wfix, input int unsigned wmax, input logic [15:0] corrupt,
                        input bit noise, input bit spray, input bit hold2, output int cyc);
        r_wait_fixed = wfix;
        r_wait_max   = wmax;
        r_corrupt    = corrupt;
        r_noise      = noise;
        r_txn        = 0;
        r_seen       = 1'b0;
        r_gap        = 0;
        r_in_txn     = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < 3000) begin
            @(negedge clk);
            start0 = 1'b0;
            cyc++;
            if (cyc == 1) begin
                if (hold2) start0 = 1'b1;
                checks++;
                if ({b0.mem_valid, busy0, done0, timeout0, err0, first0} !==
                    {1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0}) begin
                    failures++;
                    $display("FAIL run_launch got valid=%b busy=%b done=%b to=%b err=%0d first=%h exp 1 1 0 0 0 0",
                             b0.mem_valid, busy0, done0, timeout0, err0, first0);
                end
            end
            if (done0) break;
            if (spray && cyc > 1) start0 = 1'($urandom_range(1, 0));
        end
        start0 = 1'b0;
        checks++;
        if (done0 !== 1'b1) begin
            failures++;
            $display("FAIL run_done_bound got done=%b after %0d cycles exp 1", done0, cyc);
        end
        checks++;
        if (r_txn != 2 * Nw) begin
            failures++;
            $display("FAIL txn_count got %0d exp %0d", r_txn, 2 * Nw);
        end
        checks++;
        if ({busy0, b0.mem_valid, timeout0} !== 3'b000) begin
            failures++;
            $display("FAIL run_end_flags got busy=%b valid=%b to=%b exp 0 0 0",
                     busy0, b0.mem_valid, timeout0);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({b0.mem_valid, b0.mem_instr, b0.mem_addr, b0.mem_wdata, b0.mem_wstrb, busy0, done0,
             err0, first0, timeout0} !== '0) begin
            failures++;
            $display("FAIL reset_dut0 got valid=%b addr=%h wdata=%h wstrb=%h busy=%b done=%b err=%0d first=%h to=%b exp all 0",
                     b0.mem_valid, b0.mem_addr, b0.mem_wdata, b0.mem_wstrb, busy0, done0, err0,
                     first0, timeout0);
        end
        checks++;
        if ({busy1, done1, timeout1, busy2, done2, b1.mem_valid, b2.mem_valid} !== '0) begin
            failures++;
            $display("FAIL reset_others got busy1=%b done1=%b to1=%b busy2=%b done2=%b exp 0",
                     busy1, done1, timeout1, busy2, done2);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b0.mem_valid, busy0, done0} !== 3'b000) begin
            failures++;
            $display("FAIL idle_wait got valid=%b busy=%b done=%b exp 0 0 0",
                     b0.mem_valid, busy0, done0);
        end
    endtask

    task automatic test_zero_wait();
        int cyc;
        run0(0, 0, '0, 1'b0, 1'b0, 1'b1, cyc);
        checks++;
        if (cyc != 64) begin
            failures++;
            $display("FAIL zero_wait_latency got %0d exp 64", cyc);
        end
        checks++;
        if (err0 !== 16'd0 || first0 !== 32'd0) begin
            failures++;
            $display("FAIL zero_wait_err got err=%0d first=%h exp 0 0", err0, first0);
        end
    endtask

    task automatic test_wait_states();
        int cyc;
        run0(3, 0, '0, 1'b1, 1'b0, 1'b0, cyc);
        checks++;
        if (cyc != 32 * 5) begin
            failures++;
            $display("FAIL wait3_latency got %0d exp %0d", cyc, 32 * 5);
        end
        checks++;
        if (err0 !== 16'd0) begin
            failures++;
            $display("FAIL wait3_err got %0d exp 0", err0);
        end
    endtask

    task automatic test_corrupt();
        int cyc;
        run0(1, 0, 16'h0220, 1'b0, 1'b0, 1'b0, cyc);
        checks++;
        if (err0 !== 16'd2 || first0 !== 32'h0000_1014) begin
            failures++;
            $display("FAIL corrupt_5_9 got err=%0d first=%h exp 2 00001014", err0, first0);
        end
    endtask

    task automatic test_random();
        int          cyc;
        int          exp_err;
        logic [31:0] exp_first;
        logic [15:0] mask;
        for (int it = 0; it < 4; it++) begin
            mask      = 16'($urandom);
            exp_err   = 0;
            exp_first = '0;
            for (int i = Nw - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    exp_err++;
                    exp_first = Base + 32'(4 * i);
                end
            end
            run0(-1, 3, mask, 1'b1, 1'b1, 1'b0, cyc);
            checks++;
            if (err0 !== 16'(exp_err) || first0 !== exp_first) begin
                failures++;
                $display("FAIL random%0d mask=%h got err=%0d first=%h exp %0d %h",
                         it, mask, err0, first0, exp_err, exp_first);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int cyc;
        r_wait_fixed = 2;
        r_corrupt    = '0;
        r_noise      = 1'b0;
        r_txn        = 0;
        r_seen       = 1'b0;
        r_gap        = 0;
        r_in_txn     = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        while (!(r_txn == 3 && b0.mem_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL reach_4th_write got txn=%0d exp 3", r_txn);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({b0.mem_valid, b0.mem_instr, b0.mem_addr, b0.mem_wdata, b0.mem_wstrb, busy0, done0,
             err0, first0, timeout0} !== '0) begin
            failures++;
            $display("FAIL reset_async got valid=%b addr=%h wdata=%h wstrb=%h busy=%b exp all 0",
                     b0.mem_valid, b0.mem_addr, b0.mem_wdata, b0.mem_wstrb, busy0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({b0.mem_valid, b0.mem_addr, b0.mem_wdata, b0.mem_wstrb, busy0, done0} !== '0) begin
            failures++;
            $display("FAIL reset_hold got valid=%b addr=%h busy=%b done=%b exp all 0",
                     b0.mem_valid, b0.mem_addr, busy0, done0);
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({b0.mem_valid, busy0, done0} !== 3'b000) begin
                failures++;
                $display("FAIL idle_after_reset got valid=%b busy=%b done=%b exp 0 0 0",
                         b0.mem_valid, busy0, done0);
            end
        end
        run0(1, 0, '0, 1'b1, 1'b0, 1'b0, cyc);
        checks++;
        if (err0 !== 16'd0 || timeout0 !== 1'b0) begin
            failures++;
            $display("FAIL rerun_clean got err=%0d to=%b exp 0 0", err0, timeout0);
        end
    endtask

    task automatic test_timeout();
        int stall = 0;
        int guard = 0;
        int vcnt  = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && guard < 200) begin
            if (b1.mem_valid && t1_hs == 2) stall++;
            @(negedge clk);
            guard++;
        end
        checks++;
        if (stall != 8) begin
            failures++;
            $display("FAIL timeout_stall got %0d cycles exp 8", stall);
        end
        checks++;
        if ({timeout1, done1, busy1, b1.mem_valid} !== 4'b1100) begin
            failures++;
            $display("FAIL timeout_flags got to=%b done=%b busy=%b valid=%b exp 1 1 0 0",
                     timeout1, done1, busy1, b1.mem_valid);
        end
        repeat (10) begin
            @(negedge clk);
            if (b1.mem_valid) vcnt++;
        end
        checks++;
        if (vcnt != 0 || t1_hs != 2 || t1_reads != 0 || done1 !== 1'b1) begin
            failures++;
            $display("FAIL timeout_quiet got valid_cycles=%0d hs=%0d reads=%0d done=%b exp 0 2 0 1",
                     vcnt, t1_hs, t1_reads, done1);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] ta [4];
        logic [31:0] td [4];
        logic [3:0]  ts [4];
        int n = 0;
        int cyc = 0;
        int dcyc = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        while (cyc < 20) begin
            @(negedge clk);
            start2 = 1'b0;
            cyc++;
            if (b2.mem_valid && n < 4) begin
                ta[n] = b2.mem_addr;
                td[n] = b2.mem_wdata;
                ts[n] = b2.mem_wstrb;
                n++;
            end
            if (done2 && dcyc == 0) dcyc = cyc;
        end
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL single_count got %0d exp 2", n);
        end else begin
            checks++;
            if (ta[0] !== 32'hFFFF_FFFC || td[0] !== 32'h5A5A_A5A6 || ts[0] !== 4'hF) begin
                failures++;
                $display("FAIL single_write got %h/%h/%h exp fffffffc/5a5aa5a6/f",
                         ta[0], td[0], ts[0]);
            end
            checks++;
            if (ta[1] !== 32'hFFFF_FFFC || td[1] !== 32'h0 || ts[1] !== 4'h0) begin
                failures++;
                $display("FAIL single_read got %h/%h/%h exp fffffffc/00000000/0",
                         ta[1], td[1], ts[1]);
            end
        end
        checks++;
        if (dcyc != 4 || err2 !== 16'd0 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL single_done got done_cycle=%0d err=%0d busy=%b exp 4 0 0",
                     dcyc, err2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_corrupt();
        test_random();
        test_timeout();
        test_single_word();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit exceeded");
        $fatal(1);
    end

endmodule
